// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial out = in1 - in2, LSB digit first, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor #(
  parameter int BUS_WIDTH   = 32,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 borrow
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic                 overflow
`endif
);
  localparam int NUM_DIGITS = BUS_WIDTH / DIGIT_WIDTH;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  if (BUS_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_width
    $error("DIGIT_WIDTH must divide BUS_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [BUS_WIDTH-1:0] a, b, res, res_next;
  logic [BUS_WIDTH+DIGIT_WIDTH-1:0] cat;
  logic [DIGIT_WIDTH:0] sum;
  logic [CW-1:0] cnt;
  logic c, last;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic s1, s2;
`endif

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last = cnt == CW'(NUM_DIGITS - 1);
  assign sum = {1'b0, a[DIGIT_WIDTH-1:0]} + {1'b0, ~b[DIGIT_WIDTH-1:0]} + {{DIGIT_WIDTH{1'b0}}, c};
  // Shift the new digit in at the MSB end; works even when only one digit exists.
  assign cat = {sum[DIGIT_WIDTH-1:0], res} >> DIGIT_WIDTH;
  assign res_next = cat[BUS_WIDTH-1:0];

  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_next;

  always_comb begin
    state_next = state;
    state_next = state == IDLE ? (in_valid ? RUN : IDLE) :
                 state == RUN  ? (last ? DONE : RUN) :
                                 (out_ready ? IDLE : DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      res    <= '0;
      out    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      c      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      s1       <= 1'b0;
      s2       <= 1'b0;
      overflow <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a   <= in1;
      b   <= in2;
      cnt <= '0;
      c   <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      s1 <= in1[BUS_WIDTH-1];
      s2 <= in2[BUS_WIDTH-1];
`endif
    end else if (state == RUN) begin
      a   <= a >> DIGIT_WIDTH;
      b   <= b >> DIGIT_WIDTH;
      res <= res_next;
      c   <= sum[DIGIT_WIDTH];
      cnt <= cnt + CW'(1);
      if (last) begin
        out    <= res_next;
        borrow <= ~sum[DIGIT_WIDTH];
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        overflow <= (s1 != s2) && (res_next[BUS_WIDTH-1] != s1);
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor at default parameters.
module tb_serial_subtractor;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in1 = 0, in2 = 0, out;
  logic in_ready, out_valid, borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic overflow;
`endif
  int total = 0, bad = 0, n;
  logic [31:0] held;

  serial_subtractor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .borrow(borrow)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic start(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in1 = x;
    in2 = y;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic release_out();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_borrow", {31'd0, borrow}, 32'd0);

    start(32'h0000_1234, 32'h0000_0234);
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    wait_valid();
    chk("latency", n, 32'd8);
    chk("basic_out", out, 32'h0000_1000);
    chk("basic_borrow", {31'd0, borrow}, 32'd0);
    release_out();

    start(32'h0000_0000, 32'h0000_0001);
    wait_valid();
    chk("wrap_out", out, 32'hFFFF_FFFF);
    chk("wrap_borrow", {31'd0, borrow}, 32'd1);
    held = out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out", out, held);
      chk("bp_borrow", {31'd0, borrow}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    release_out();

    start(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wait_valid();
    chk("eq_out", out, 32'd0);
    chk("eq_borrow", {31'd0, borrow}, 32'd0);
    release_out();

    start(32'h1234_5678, 32'h8765_4321);
    wait_valid();
    chk("mix_out", out, 32'h8ACF_1357);
    chk("mix_borrow", {31'd0, borrow}, 32'd1);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    chk("mix_ovf", {31'd0, overflow}, 32'd1);
`endif
    release_out();

    start(32'h8000_0000, 32'h0000_0001);
    wait_valid();
    chk("ovf_out", out, 32'h7FFF_FFFF);
    chk("ovf_borrow", {31'd0, borrow}, 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
`endif
    release_out();

    start(32'd100, 32'd1);
    repeat (3) @(negedge clk);
    in1 = 32'd5;
    in2 = 32'd7;
    in_valid = 1;
    wait_valid();
    chk("busy_out", out, 32'h0000_0063);
    chk("busy_borrow", {31'd0, borrow}, 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    chk("busy_ovf", {31'd0, overflow}, 32'd0);
`endif
    release_out();
    @(negedge clk);
    in_valid = 0;
    wait_valid();
    chk("second_latency", n, 32'd8);
    chk("second_out", out, 32'hFFFF_FFFE);
    chk("second_borrow", {31'd0, borrow}, 32'd1);
    release_out();

    start(32'hFFFF_0000, 32'h0000_0001);
    repeat (3) @(negedge clk);
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out", out, 32'd0);
    chk("mid_rst_borrow", {31'd0, borrow}, 32'd0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("mid_rst_no_valid", n, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
